// File: rtl/a2bus_read_arbiter.sv
// a2bus_read_arbiter: round-robin arbiter sharing the Apple II data-bus drive path between read responders
// Ports: clk_logic_i / system_reset_n_i logic clock and async active-low reset; enable_i arbiter enable;
//   phi0_posedge_i / phi0_negedge_i phase pulses; addr_valid_i / rw_n_i address strobe and latched R/W;
//   req_i / rd_data_i requester claims and bytes; grant_o / ack_o one-hot winner and completion pulse;
//   data_o / data_oe_o bus byte and drive enable; conflict_count_o saturating multi-request count;
//   error_o sticky timeout/overrun flag.
module a2bus_read_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DRIVE_START_COUNT = 4,
  parameter int DRIVE_HOLD_COUNT  = 3,
  parameter int TIMEOUT_COUNT     = 60
) (
  input  logic                 clk_logic_i,
  input  logic                 system_reset_n_i,
  input  logic                 enable_i,
  input  logic                 phi0_posedge_i,
  input  logic                 phi0_negedge_i,
  input  logic                 addr_valid_i,
  input  logic                 rw_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] rd_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [7:0]           data_o,
  output logic                 data_oe_o,
  output logic [7:0]           conflict_count_o,
  output logic                 error_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  localparam logic [5:0] START_CNT = 6'(DRIVE_START_COUNT);
  localparam logic [5:0] HOLD_CNT  = 6'(DRIVE_HOLD_COUNT);
  localparam logic [5:0] TO_LAST   = 6'(TIMEOUT_COUNT - 1);
  localparam logic [2:0] LAST_REQ  = 3'(NUM_REQ - 1);
  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [2:0]         ptr;
  logic [2:0]         gidx;
  logic [2:0]         hi_idx;
  logic [2:0]         lo_idx;
  logic [2:0]         win_idx;
  logic               hi_hit;
  logic               phase_seen;
  logic               multi;
  logic               take;
  logic [NUM_REQ-1:0] win_onehot;
  logic [7:0]         win_byte;
  // Round-robin: lowest requester at or above ptr, else wrap to the lowest requester overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) lo_idx = 3'(i);
      if (req_i[i] && 3'(i) >= ptr) begin
        hi_idx = 3'(i);
        hi_hit = 1'b1;
      end
    end
  end
  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == 3'(i)) win_byte = rd_data_i[8*i +: 8];
    end
  end
  assign win_idx    = hi_hit ? hi_idx : lo_idx;
  assign win_onehot = NUM_REQ'(1) << win_idx;
  assign multi      = $countones(req_i) > 1;
  assign take       = addr_valid_i && rw_n_i && (|req_i) && enable_i;
  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      state            <= IDLE;
      cnt              <= '0;
      ptr              <= '0;
      gidx             <= '0;
      phase_seen       <= 1'b0;
      grant_o          <= '0;
      ack_o            <= '0;
      data_o           <= '0;
      data_oe_o        <= 1'b0;
      conflict_count_o <= '0;
      error_o          <= 1'b0;
    end else begin
      ack_o <= '0;
      if (addr_valid_i && state != IDLE) error_o <= 1'b1;
      if (state != IDLE && !enable_i) begin
        state     <= IDLE;
        grant_o   <= '0;
        data_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (take) begin
              state      <= ARMED;
              grant_o    <= win_onehot;
              gidx       <= win_idx;
              ptr        <= (win_idx == LAST_REQ) ? 3'd0 : win_idx + 3'd1;
              cnt        <= '0;
              phase_seen <= 1'b0;
              if (multi && conflict_count_o != 8'hFF) conflict_count_o <= conflict_count_o + 8'd1;
            end
          end
          ARMED: begin
            if (phi0_posedge_i) begin
              cnt        <= '0;
              phase_seen <= 1'b1;
            end else if (phase_seen && cnt == START_CNT) begin
              data_o    <= win_byte;
              data_oe_o <= 1'b1;
              state     <= DRIVE;
              cnt       <= '0;
            end else if (cnt == TO_LAST) begin
              state   <= IDLE;
              grant_o <= '0;
              error_o <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          DRIVE: begin
            if (phi0_negedge_i) begin
              state <= HOLD;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state     <= IDLE;
              grant_o   <= '0;
              data_oe_o <= 1'b0;
              error_o   <= 1'b1;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          default: begin
            if (cnt == HOLD_CNT) begin
              state     <= IDLE;
              grant_o   <= '0;
              data_oe_o <= 1'b0;
              ack_o     <= grant_o;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_a2bus_read_arbiter.sv
// tb_a2bus_read_arbiter: scoreboard bench for a2bus_read_arbiter with a queue-based reference model
module tb_a2bus_read_arbiter;
  localparam int N  = 4;
  localparam int DS = 4;
  localparam int DH = 3;
  localparam int TO = 60;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  logic pp    = 1'b0;
  logic pn    = 1'b0;
  logic av    = 1'b0;
  logic rw    = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] rd  = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [7:0]     dout;
  logic [7:0]     cc;
  logic           oe;
  logic           err;
  int checks = 0;
  int passes = 0;
  int m_ptr  = 0;
  int m_conf = 0;
  logic m_err = 1'b0;
  logic [N-1:0] q_grant[$];
  logic [N-1:0] q_ack[$];
  logic [7:0]   q_data[$];
  a2bus_read_arbiter #(
    .NUM_REQ(N), .DRIVE_START_COUNT(DS), .DRIVE_HOLD_COUNT(DH), .TIMEOUT_COUNT(TO)
  ) dut (
    .clk_logic_i(clk), .system_reset_n_i(rst_n), .enable_i(en),
    .phi0_posedge_i(pp), .phi0_negedge_i(pn), .addr_valid_i(av), .rw_n_i(rw),
    .req_i(req), .rd_data_i(rd), .grant_o(grant), .ack_o(ack), .data_o(dout),
    .data_oe_o(oe), .conflict_count_o(cc), .error_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic model_reset();
    m_ptr  = 0;
    m_conf = 0;
    m_err  = 1'b0;
    q_grant.delete();
    q_ack.delete();
    q_data.delete();
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_data"}, 32'(dout), 0);
    chk({tag, "_oe"}, 32'(oe), 0);
    chk({tag, "_conflicts"}, 32'(cc), 0);
    chk({tag, "_error"}, 32'(err), 0);
  endtask
  // Monitor: pops expectations whenever the DUT presents a grant, a drive start or an ack.
  initial begin
    logic [N-1:0] pg;
    logic po;
    pg = '0;
    po = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (grant != '0 && pg == '0) begin
          if (q_grant.size() == 0) unexpected("sb_grant", 32'(grant));
          else chk("sb_grant", 32'(grant), 32'(q_grant.pop_front()));
        end
        if (oe && !po) begin
          if (q_data.size() == 0) unexpected("sb_data", 32'(dout));
          else chk("sb_data", 32'(dout), 32'(q_data.pop_front()));
        end
        if (ack != '0) begin
          if (q_ack.size() == 0) unexpected("sb_ack", 32'(ack));
          else chk("sb_ack", 32'(ack), 32'(q_ack.pop_front()));
        end
      end
      pg = grant;
      po = oe;
    end
  end
  // mode: 0 normal, 1 no phase edge, 2 enable drop in DRIVE, 3 overrun in DRIVE, 4 reset in DRIVE
  task automatic bus_cycle(input logic [N-1:0] r, input logic rwv, input logic [8*N-1:0] rdv,
                           input int mode, input bit coincide);
    logic [N-1:0] g;
    logic [7:0] b;
    int w;
    bit go;
    go = rwv && (r != '0);
    g = '0;
    b = '0;
    w = 0;
    if (go) begin
      w = winner(r, m_ptr);
      g = N'(1) << w;
      b = rdv[8*w +: 8];
      m_ptr = (w + 1) % N;
      if ($countones(r) > 1 && m_conf < 255) m_conf++;
      q_grant.push_back(g);
    end
    req = r;
    rw = rwv;
    rd = $urandom;
    av = 1'b1;
    pp = coincide;
    tick();
    av = 1'b0;
    pp = 1'b0;
    chk("grant_latency", 32'(grant), 32'(g));
    if (!go) begin
      repeat (2) tick();
      pp = 1'b1;
      tick();
      pp = 1'b0;
      repeat (DS + 2) tick();
      pn = 1'b1;
      tick();
      pn = 1'b0;
      repeat (DH + 2) tick();
      chk("filtered_oe", 32'(oe), 0);
      chk("filtered_grant", 32'(grant), 0);
      return;
    end
    if (mode == 1) begin
      repeat (TO - 1) tick();
      chk("timeout_pending", 32'(grant), 32'(g));
      tick();
      m_err = 1'b1;
      chk("timeout_grant", 32'(grant), 0);
      chk("timeout_oe", 32'(oe), 0);
      chk("timeout_error", 32'(err), 32'(m_err));
      return;
    end
    repeat ($urandom_range(0, 4)) tick();
    pp = 1'b1;
    tick();
    pp = 1'b0;
    repeat (DS) tick();
    chk("oe_before_start", 32'(oe), 0);
    rd = rdv;
    q_data.push_back(b);
    tick();
    chk("oe_at_start", 32'(oe), 1);
    chk("data_latched", 32'(dout), 32'(b));
    rd = $urandom;
    tick();
    if (mode == 2) begin
      en = 1'b0;
      tick();
      en = 1'b1;
      chk("disable_oe", 32'(oe), 0);
      chk("disable_grant", 32'(grant), 0);
      chk("disable_error", 32'(err), 32'(m_err));
      return;
    end
    if (mode == 4) begin
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    if (mode == 3) begin
      req = N'($urandom);
      av = 1'b1;
      tick();
      av = 1'b0;
      m_err = 1'b1;
      chk("overrun_grant", 32'(grant), 32'(g));
      chk("overrun_error", 32'(err), 1);
    end
    repeat ($urandom_range(0, 6)) tick();
    chk("data_frozen", 32'(dout), 32'(b));
    pn = 1'b1;
    q_ack.push_back(g);
    tick();
    pn = 1'b0;
    repeat (DH) tick();
    chk("oe_in_hold", 32'(oe), 1);
    chk("ack_in_hold", 32'(ack), 0);
    tick();
    chk("oe_release", 32'(oe), 0);
    chk("ack_release", 32'(ack), 32'(g));
    chk("grant_release", 32'(grant), 0);
    chk("conflicts", 32'(cc), 32'(m_conf));
    chk("error", 32'(err), 32'(m_err));
  endtask
  initial begin
    int sel;
    int mode;
    logic rwv;
    logic [N-1:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    bus_cycle(4'b0100, 1'b1, {8'h11, 8'hA5, 8'h22, 8'h33}, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    model_reset();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) bus_cycle(4'b1111, 1'b1, $urandom, 0, 1'b0);
    chk("rr_conflicts", 32'(cc), 32'(m_conf));
    for (int i = 0; i < 300; i++) bus_cycle(4'b1001, 1'b1, $urandom, 0, 1'b0);
    chk("saturated_conflicts", 32'(cc), 32'(m_conf));
    bus_cycle(4'b1111, 1'b0, $urandom, 0, 1'b0);
    bus_cycle(4'b0000, 1'b1, $urandom, 0, 1'b0);
    bus_cycle(4'b0110, 1'b1, $urandom, 1, 1'b0);
    bus_cycle(4'b1010, 1'b1, $urandom, 3, 1'b0);
    bus_cycle(4'b0011, 1'b1, $urandom, 2, 1'b0);
    bus_cycle(4'b1100, 1'b1, $urandom, 4, 1'b0);
    bus_cycle(4'b1111, 1'b1, $urandom, 0, 1'b0);
    bus_cycle(4'b1000, 1'b1, $urandom, 0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 19));
      mode = (sel < 12) ? 0 : (sel < 14) ? 2 : (sel < 16) ? 3 : (sel == 16) ? 1 : 0;
      rwv = (sel == 17) ? 1'b0 : 1'b1;
      r = (sel == 18) ? '0 : N'($urandom_range(1, 15));
      bus_cycle(r, rwv, $urandom, mode, $urandom_range(0, 3) == 0);
    end
    repeat (3) tick();
    chk("grants_outstanding", 32'(q_grant.size()), 0);
    chk("data_outstanding", 32'(q_data.size()), 0);
    chk("acks_outstanding", 32'(q_ack.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
